// File: rtl/spmv_pkg.sv
// Shared constants and types for the SpMV memory arbiter: stream indices,
// transaction-ID layout and DCP port widths.
package spmv_pkg;

   localparam int TRANSID_W  = 6;
   localparam int REQ_BITS   = 2;
   localparam int TAG_BITS   = TRANSID_W - REQ_BITS;
   localparam int NUM_REQ    = 1 << REQ_BITS;
   localparam int PADDR_W    = 40;
   localparam int RES_DATA_W = 512;

   typedef enum logic [REQ_BITS-1:0] {
      REQ_ROWPTR = 2'd0,
      REQ_COLIDX = 2'd1,
      REQ_VAL    = 2'd2,
      REQ_XVEC   = 2'd3
   } spmv_req_e;

   typedef struct packed {
      logic [REQ_BITS-1:0] req;
      logic [TAG_BITS-1:0] tag;
   } transid_t;

endpackage

// File: rtl/spmv_rr_arbiter.sv
// Round-robin arbiter: the search starts at rr_ptr, and rr_ptr moves to
// just past the winner whenever the grant is consumed.
module spmv_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] idx;
   logic             found;

   // The index wraps by truncation, so N must be a power of two.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      gnt     = '0;
      gnt_idx = '0;
      idx     = '0;
      found   = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = rr_ptr + IDX_W'(k);
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (rst)
         rr_ptr <= '0;
      else if (advance)
         rr_ptr <= gnt_idx + IDX_W'(1);
   end

endmodule

// File: rtl/spmv_mem_arbiter.sv
// Shares one DCP memory port among the SpMV fetch streams: round-robin grant,
// transid allocation, per-stream credit caps and response routing by transid.
module spmv_mem_arbiter
   import spmv_pkg::*;
#(
   parameter int MAX_OUTST = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_val,
   output logic [NUM_REQ-1:0]                req_rdy,
   input  logic [NUM_REQ-1:0][PADDR_W-1:0]   req_addr,
   output logic                              mem_req_val,
   input  logic                              mem_req_rdy,
   output logic [TRANSID_W-1:0]              mem_req_transid,
   output logic [PADDR_W-1:0]                mem_req_addr,
   input  logic                              mem_resp_val,
   input  logic [TRANSID_W-1:0]              mem_resp_transid,
   input  logic [RES_DATA_W-1:0]             mem_resp_data,
   output logic [NUM_REQ-1:0]                resp_val,
   output logic [TAG_BITS-1:0]               resp_tag,
   output logic [RES_DATA_W-1:0]             resp_data,
   output logic                              idle,
   output logic                              err_spurious
);

   localparam int CNT_W = TAG_BITS + 1;

   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  gnt;
   logic [REQ_BITS-1:0] gnt_idx;
   logic                can_load;
   logic                accept;

   logic [CNT_W-1:0]    outst   [NUM_REQ];
   logic [TAG_BITS-1:0] tag_cnt [NUM_REQ];

   logic                out_val;
   transid_t            out_id;
   logic [PADDR_W-1:0]  out_addr;

   transid_t            rsp_id;
   logic                rsp_live;
   logic                rsp_hit;

   assign can_load = !out_val || mem_req_rdy;

   // Eligibility uses the registered credit count, so a same-cycle response does not reopen a capped stream.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_val[i] && (outst[i] < CNT_W'(MAX_OUTST));
   end

   assign accept  = !rst && can_load && (|eligible);
   assign req_rdy = accept ? gnt : '0;

   spmv_rr_arbiter #(.N(NUM_REQ), .IDX_W(REQ_BITS)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (eligible),
      .advance (accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign rsp_id    = mem_resp_transid;
   assign rsp_live  = (outst[rsp_id.req] != '0);
   assign rsp_hit   = !rst && mem_resp_val && rsp_live;
   assign resp_val  = rsp_hit ? (NUM_REQ'(1) << rsp_id.req) : '0;
   assign resp_tag  = rsp_id.tag;
   assign resp_data = mem_resp_data;

   assign mem_req_val     = out_val;
   assign mem_req_transid = out_id;
   assign mem_req_addr    = out_addr;

   always_comb begin
      idle = !out_val;
      for (int i = 0; i < NUM_REQ; i++)
         if (outst[i] != '0) idle = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_val      <= 1'b0;
         out_id       <= '0;
         out_addr     <= '0;
         err_spurious <= 1'b0;
         // NOTE: these per-stream arrays are small flop banks, not RAM, so they can and must be reset to keep credits consistent.
         for (int i = 0; i < NUM_REQ; i++) begin
            outst[i]   <= '0;
            tag_cnt[i] <= '0;
         end
      end else begin
         if (can_load) begin
            out_val <= accept;
            if (accept) begin
               out_id   <= '{req: gnt_idx, tag: tag_cnt[gnt_idx]};
               out_addr <= req_addr[gnt_idx];
            end
         end
         if (accept)
            tag_cnt[gnt_idx] <= tag_cnt[gnt_idx] + TAG_BITS'(1);
         for (int i = 0; i < NUM_REQ; i++) begin
            case ({accept && gnt[i], resp_val[i]})
               2'b10:   outst[i] <= outst[i] + CNT_W'(1);
               2'b01:   outst[i] <= outst[i] - CNT_W'(1);
               default: ;
            endcase
         end
         if (mem_resp_val && !rsp_live)
            err_spurious <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Scoreboarded bench for spmv_mem_arbiter: expected memory requests are queued
// when stimulus is driven and compared as the DUT presents them.
module tb_spmv_mem_arbiter;
   import spmv_pkg::*;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [NUM_REQ-1:0]              req_val;
   logic [NUM_REQ-1:0]              req_rdy;
   logic [NUM_REQ-1:0][PADDR_W-1:0] req_addr;
   logic                            mem_req_val;
   logic                            mem_req_rdy;
   logic [TRANSID_W-1:0]            mem_req_transid;
   logic [PADDR_W-1:0]              mem_req_addr;
   logic                            mem_resp_val;
   logic [TRANSID_W-1:0]            mem_resp_transid;
   logic [RES_DATA_W-1:0]           mem_resp_data;
   logic [NUM_REQ-1:0]              resp_val;
   logic [TAG_BITS-1:0]             resp_tag;
   logic [RES_DATA_W-1:0]           resp_data;
   logic                            idle;
   logic                            err_spurious;

   int checks = 0;
   int errors = 0;

   logic [TRANSID_W+PADDR_W-1:0] exp_q  [$];
   logic [TRANSID_W-1:0]         pend_q [$];

   always #5 clk = ~clk;

   spmv_mem_arbiter #(.MAX_OUTST(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_val          (req_val),
      .req_rdy          (req_rdy),
      .req_addr         (req_addr),
      .mem_req_val      (mem_req_val),
      .mem_req_rdy      (mem_req_rdy),
      .mem_req_transid  (mem_req_transid),
      .mem_req_addr     (mem_req_addr),
      .mem_resp_val     (mem_resp_val),
      .mem_resp_transid (mem_resp_transid),
      .mem_resp_data    (mem_resp_data),
      .resp_val         (resp_val),
      .resp_tag         (resp_tag),
      .resp_data        (resp_data),
      .idle             (idle),
      .err_spurious     (err_spurious)
   );

   // Scoreboard: every memory-side handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && mem_req_val && mem_req_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_req_unexpected: got transid=%h addr=%h, required no request", mem_req_transid, mem_req_addr);
         end else begin
            logic [TRANSID_W+PADDR_W-1:0] e;
            e = exp_q.pop_front();
            if ({mem_req_transid, mem_req_addr} !== e) begin
               errors++;
               $display("FAIL mem_req: got transid=%h addr=%h, required transid=%h addr=%h",
                        mem_req_transid, mem_req_addr, e[TRANSID_W+PADDR_W-1:PADDR_W], e[PADDR_W-1:0]);
            end
            pend_q.push_back(mem_req_transid);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [TRANSID_W-1:0] id, input logic [PADDR_W-1:0] a);
      exp_q.push_back({id, a});
   endtask

   function automatic logic [RES_DATA_W-1:0] rand_data();
      logic [RES_DATA_W-1:0] d;
      for (int i = 0; i < RES_DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic reset_dut();
      rst              = 1'b1;
      req_val          = '0;
      req_addr         = '0;
      mem_req_rdy      = 1'b0;
      mem_resp_val     = 1'b0;
      mem_resp_transid = '0;
      mem_resp_data    = '0;
      repeat (2) cyc();
      exp_q.delete();
      pend_q.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      checks++;
      if ({mem_req_val, req_rdy, resp_val, idle, err_spurious} !== {1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got val=%b rdy=%b resp=%b idle=%b err=%b, required 0 0000 0000 1 0",
                  mem_req_val, req_rdy, resp_val, idle, err_spurious);
      end
   endtask

   task automatic test_single();
      logic [RES_DATA_W-1:0] d;
      reset_dut();
      req_val     = 4'b0100;
      req_addr[2] = 40'h1000;
      mem_req_rdy = 1'b1;
      push_exp(6'h20, 40'h1000);
      #1;
      checks++;
      if (req_rdy !== 4'b0100) begin
         errors++; $display("FAIL single_rdy: got %b, required 0100", req_rdy);
      end
      cyc();
      req_val = '0;
      checks++;
      if (mem_req_val !== 1'b1) begin
         errors++; $display("FAIL single_latency: got mem_req_val=%b, required 1", mem_req_val);
      end
      cyc();
      d                = rand_data();
      mem_resp_val     = 1'b1;
      mem_resp_transid = 6'h20;
      mem_resp_data    = d;
      #1;
      checks++;
      if (resp_val !== 4'b0100 || resp_tag !== 4'h0 || resp_data !== d) begin
         errors++; $display("FAIL single_resp: got resp_val=%b tag=%h, required 0100 tag 0 and data match", resp_val, resp_tag);
      end
      cyc();
      mem_resp_val = 1'b0;
      #1;
      checks++;
      if (idle !== 1'b1 || err_spurious !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL single_idle: got idle=%b err=%b pending=%0d, required 1 0 0", idle, err_spurious, exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [TRANSID_W-1:0] exp_id [5] = '{6'h00, 6'h10, 6'h20, 6'h30, 6'h01};
      reset_dut();
      for (int i = 0; i < NUM_REQ; i++) req_addr[i] = 40'h4000 + 40'(i * 'h100);
      req_val     = 4'b1111;
      mem_req_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (req_rdy !== exp_gnt[k]) begin
            errors++; $display("FAIL rr_grant%0d: got %b, required %b", k, req_rdy, exp_gnt[k]);
         end
         push_exp(exp_id[k], 40'h4000 + 40'(int'(exp_id[k][5:4]) * 'h100));
         cyc();
      end
      req_val = '0;
      cyc();
      mem_resp_val     = 1'b1;
      mem_resp_transid = 6'h01;
      #1;
      checks++;
      if (resp_val !== 4'b0001 || resp_tag !== 4'h1) begin
         errors++; $display("FAIL rr_resp: got resp_val=%b tag=%h, required 0001 tag 1", resp_val, resp_tag);
      end
      cyc();
      mem_resp_val = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL rr_drain: got %0d outstanding expectations, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      reset_dut();
      req_val     = 4'b1001;
      req_addr[0] = 40'h2000;
      req_addr[3] = 40'h3000;
      mem_req_rdy = 1'b0;
      #1;
      checks++;
      if (req_rdy !== 4'b0001) begin
         errors++; $display("FAIL bp_first: got %b, required 0001", req_rdy);
      end
      push_exp(6'h00, 40'h2000);
      cyc();
      req_addr[0] = 40'h2222;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (req_rdy !== 4'b0000 || mem_req_val !== 1'b1 || mem_req_transid !== 6'h00 || mem_req_addr !== 40'h2000) begin
            errors++;
            $display("FAIL bp_hold%0d: got rdy=%b val=%b transid=%h addr=%h, required 0000 1 00 2000",
                     k, req_rdy, mem_req_val, mem_req_transid, mem_req_addr);
         end
         cyc();
      end
      mem_req_rdy = 1'b1;
      #1;
      checks++;
      if (req_rdy !== 4'b1000) begin
         errors++; $display("FAIL bp_resume: got %b, required 1000", req_rdy);
      end
      push_exp(6'h30, 40'h3000);
      cyc();
      req_val = '0;
      repeat (2) cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL bp_drain: got %0d outstanding expectations, required 0", exp_q.size());
      end
   endtask

   task automatic test_credit_cap();
      reset_dut();
      req_addr[1] = 40'h7100;
      req_addr[3] = 40'h7300;
      req_val     = 4'b0010;
      mem_req_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++;
         if (req_rdy !== 4'b0010) begin
            errors++; $display("FAIL cap_fill%0d: got %b, required 0010", k, req_rdy);
         end
         push_exp({REQ_COLIDX, 4'(k)}, 40'h7100);
         cyc();
      end
      req_val = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (req_rdy !== 4'b1000) begin
            errors++; $display("FAIL cap_other%0d: got %b, required 1000", k, req_rdy);
         end
         push_exp({REQ_XVEC, 4'(k)}, 40'h7300);
         cyc();
      end
      req_val          = 4'b0010;
      mem_resp_val     = 1'b1;
      mem_resp_transid = 6'h13;
      #1;
      checks++;
      if (req_rdy !== 4'b0000 || resp_val !== 4'b0010 || resp_tag !== 4'h3) begin
         errors++; $display("FAIL cap_resp: got rdy=%b resp_val=%b tag=%h, required 0000 0010 3", req_rdy, resp_val, resp_tag);
      end
      cyc();
      mem_resp_val = 1'b0;
      #1;
      checks++;
      if (req_rdy !== 4'b0010) begin
         errors++; $display("FAIL cap_reopen: got %b, required 0010", req_rdy);
      end
      push_exp(6'h18, 40'h7100);
      cyc();
      req_val = '0;
      repeat (2) cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL cap_drain: got %0d outstanding expectations, required 0", exp_q.size());
      end
   endtask

   task automatic test_tag_wrap();
      logic [TRANSID_W-1:0] t;
      logic                 rsp;
      logic                 acc;
      int                   outst_m = 0;
      logic [TAG_BITS-1:0]  tag_m   = '0;
      reset_dut();
      req_addr[0] = 40'h5000;
      req_val     = 4'b0001;
      mem_req_rdy = 1'b1;
      for (int k = 0; k < 20; k++) begin
         rsp          = (pend_q.size() != 0);
         mem_resp_val = rsp;
         t            = '0;
         if (rsp) begin
            t                = pend_q.pop_front();
            mem_resp_transid = t;
         end
         #1;
         acc = (outst_m < 8);
         checks++;
         if (req_rdy !== (acc ? 4'b0001 : 4'b0000)) begin
            errors++; $display("FAIL wrap_rdy%0d: got %b, required %b", k, req_rdy, acc ? 4'b0001 : 4'b0000);
         end
         if (rsp) begin
            checks++;
            if (resp_val !== 4'b0001 || resp_tag !== t[3:0]) begin
               errors++; $display("FAIL wrap_resp%0d: got resp_val=%b tag=%h, required 0001 tag %h", k, resp_val, resp_tag, t[3:0]);
            end
            outst_m--;
         end
         if (acc) begin
            push_exp({REQ_ROWPTR, tag_m}, 40'h5000);
            tag_m++;
            outst_m++;
         end
         cyc();
      end
      req_val = '0;
      repeat (3) begin
         rsp          = (pend_q.size() != 0);
         mem_resp_val = rsp;
         if (rsp) mem_resp_transid = pend_q.pop_front();
         cyc();
      end
      mem_resp_val = 1'b0;
      #1;
      checks++;
      if (idle !== 1'b1 || err_spurious !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL wrap_idle: got idle=%b err=%b pending=%0d, required 1 0 0", idle, err_spurious, exp_q.size());
      end
   endtask

   task automatic test_spurious();
      reset_dut();
      mem_resp_val     = 1'b1;
      mem_resp_transid = 6'h30;
      #1;
      checks++;
      if (resp_val !== 4'b0000) begin
         errors++; $display("FAIL spur_resp: got %b, required 0000", resp_val);
      end
      cyc();
      mem_resp_val = 1'b0;
      checks++;
      if (err_spurious !== 1'b1) begin
         errors++; $display("FAIL spur_flag: got %b, required 1", err_spurious);
      end
      reset_dut();
      req_addr[0] = 40'h6000;
      req_addr[2] = 40'h6200;
      req_val     = 4'b0101;
      mem_req_rdy = 1'b1;
      push_exp(6'h00, 40'h6000);
      cyc();
      push_exp(6'h20, 40'h6200);
      cyc();
      rst = 1'b1;
      #1;
      checks++;
      if (req_rdy !== 4'b0000) begin
         errors++; $display("FAIL spur_rst_rdy: got %b, required 0000", req_rdy);
      end
      reset_dut();
      #1;
      checks++;
      if (idle !== 1'b1 || mem_req_val !== 1'b0 || err_spurious !== 1'b0) begin
         errors++; $display("FAIL spur_after_rst: got idle=%b val=%b err=%b, required 1 0 0", idle, mem_req_val, err_spurious);
      end
      mem_resp_val     = 1'b1;
      mem_resp_transid = 6'h20;
      #1;
      checks++;
      if (resp_val !== 4'b0000) begin
         errors++; $display("FAIL spur_late_resp: got %b, required 0000", resp_val);
      end
      cyc();
      mem_resp_val = 1'b0;
      checks++;
      if (err_spurious !== 1'b1 || idle !== 1'b1) begin
         errors++; $display("FAIL spur_late_flag: got err=%b idle=%b, required 1 1", err_spurious, idle);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_credit_cap();
      test_tag_wrap();
      test_spurious();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
